// File: rtl/bit_serializer_pkg.sv
// Shared types and sizing helpers for the bit serializer.
// Optional feature macro: SERIALIZER_PARITY_EN (appends an even-parity bit to each frame).
package bit_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

`ifdef SERIALIZER_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int cnt_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

  function automatic int frame_len(input int width);
    return width + PARITY_BITS;
  endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Prescaler for the serializer: counts 0..DIV-1 and flags the last clk cycle of each serial bit.
// tick is high on every cycle when DIV=1.
module bit_tick_gen
  import bit_serializer_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = cnt_width(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || tick) cnt_d = '0;
  end

  // NOTE: reset is synchronous here, so it sits inside the clocked branch, not the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter, MSB first, DIV clk cycles per bit, zero-gap back-to-back frames.
// Define SERIALIZER_PARITY_EN to append an even-parity bit after the data bits.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid,
  output logic             ready,
  output logic             so,
  output logic             bit_en,
  output logic             busy
);

  localparam int FL  = frame_len(WIDTH);
  localparam int BCW = cnt_width(FL);

  state_e         state_q, state_d;
  logic [FL-1:0]  shreg_q, shreg_d;
  logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
  logic           bit_en_q, bit_en_d;

  logic          tick;
  logic          last_bit;
  logic          frame_end;
  logic          ready_int;
  logic          transfer;
  logic [FL-1:0] load_word;

`ifdef SERIALIZER_PARITY_EN
  assign load_word = {data_in, ^data_in};
`else
  assign load_word = data_in;
`endif

  // Ready is asserted on the final cycle of a frame so the next word can follow with no gap.
  assign last_bit  = (bit_cnt_q == BCW'(FL - 1));
  assign frame_end = (state_q == SHIFT) && tick && last_bit;
  assign ready_int = (state_q == IDLE) || frame_end;
  assign transfer  = valid && ready_int && !reset;

  bit_tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (transfer || (state_q == IDLE)),
    .tick  (tick)
  );

  // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    bit_en_d  = 1'b0;
    if (transfer) begin
      state_d   = SHIFT;
      shreg_d   = load_word;
      bit_cnt_d = '0;
      bit_en_d  = 1'b1;
    end else if ((state_q == SHIFT) && tick) begin
      if (last_bit) begin
        state_d   = IDLE;
        shreg_d   = '0;
        bit_cnt_d = '0;
      end else begin
        shreg_d   = {shreg_q[FL-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + BCW'(1);
        bit_en_d  = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      bit_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      bit_en_q  <= bit_en_d;
    end
  end

  // Outputs are forced quiet for the whole time reset is held, not just after its first edge.
  assign ready  = ready_int && !reset;
  assign busy   = (state_q == SHIFT) && !reset;
  assign so     = shreg_q[FL-1] && !reset;
  assign bit_en = bit_en_q && !reset;

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench: DIV=1 and DIV=4 instances against a queue-based waveform model,
// directed vector table, multi-cycle corner sequences and randomized traffic.
module tb_bit_serializer;

`ifdef SERIALIZER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FL = 8 + PAR;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       valid = 1'b0;
  logic [7:0] data_in = 8'h00;

  logic r1, s1, e1, b1;
  logic r4, s4, e4, b4;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .DIV(1)) u_div1 (
    .clk(clk), .reset(reset), .data_in(data_in), .valid(valid),
    .ready(r1), .so(s1), .bit_en(e1), .busy(b1)
  );

  bit_serializer #(.WIDTH(8), .DIV(4)) u_div4 (
    .clk(clk), .reset(reset), .data_in(data_in), .valid(valid),
    .ready(r4), .so(s4), .bit_en(e4), .busy(b4)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bits of one frame, first-transmitted bit at the top.
  function automatic logic [FL-1:0] frame_bits(input logic [7:0] w);
    logic [FL-1:0] fb;
    fb = '0;
    for (int i = 0; i < 8; i++) fb[FL-1-i] = w[7-i];
    if (PAR == 1) fb[0] = ^w;
    return fb;
  endfunction

  // Reference model: one queue entry {so, bit_en} per future clk cycle of the frame in flight.
  logic [1:0]    q1[$];
  logic [1:0]    q4[$];
  bit            t1, t4;
  logic [FL-1:0] mfb;

  always @(posedge clk) begin
    if (reset) begin
      q1.delete();
      q4.delete();
    end else begin
      t1  = valid && (q1.size() <= 1);
      t4  = valid && (q4.size() <= 1);
      mfb = frame_bits(data_in);
      if (q1.size() > 0) void'(q1.pop_front());
      if (q4.size() > 0) void'(q4.pop_front());
      if (t1)
        for (int i = FL - 1; i >= 0; i--) q1.push_back({mfb[i], 1'b1});
      if (t4)
        for (int i = FL - 1; i >= 0; i--)
          for (int c = 0; c < 4; c++) q4.push_back({mfb[i], c == 0});
    end
  end

  task automatic cmp_model();
    logic [3:0] x1, x4;
    x1 = reset ? 4'b0000 : {q1.size() <= 1, q1.size() > 0, (q1.size() > 0) ? q1[0] : 2'b00};
    x4 = reset ? 4'b0000 : {q4.size() <= 1, q4.size() > 0, (q4.size() > 0) ? q4[0] : 2'b00};
    check("model_div1 {ready,busy,so,bit_en}", {r1, b1, s1, e1}, x1);
    check("model_div4 {ready,busy,so,bit_en}", {r4, b4, s4, e4}, x4);
  endtask

  task automatic step();
    @(negedge clk);
    cmp_model();
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    reset = 1'b0;
    repeat (n) step();
  endtask

  typedef struct {
    logic       rst;
    logic       vld;
    logic [7:0] d;
    logic [3:0] exp;   // {ready, busy, so, bit_en} of the DIV=1 instance
  } vec_t;

  vec_t        tbl[$];
  int          strobes, busy_cnt;
  logic [31:0] acc, want;

  initial begin
    // Word 8'b1101_0110 on the DIV=1 instance, from reset.
    tbl.push_back('{1'b1, 1'b0, 8'h00, 4'b0000});
    tbl.push_back('{1'b0, 1'b1, 8'hD6, 4'b0111});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 4'b0111});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 4'b0101});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 4'b0111});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 4'b0101});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 4'b0111});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 4'b0111});
`ifdef SERIALIZER_PARITY_EN
    tbl.push_back('{1'b0, 1'b0, 8'h00, 4'b0101});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 4'b1111});
`else
    tbl.push_back('{1'b0, 1'b0, 8'h00, 4'b1101});
`endif
    tbl.push_back('{1'b0, 1'b0, 8'h00, 4'b1000});

    @(negedge clk);
    foreach (tbl[i]) begin
      reset   = tbl[i].rst;
      valid   = tbl[i].vld;
      data_in = tbl[i].d;
      step();
      check($sformatf("vec%0d", i), {r1, b1, s1, e1}, tbl[i].exp);
    end
    idle(40);

    // DIV=4, word 8'hA5: one strobe per bit, busy for FL*4 cycles.
    valid = 1'b1; data_in = 8'hA5;
    step();
    strobes = 32'(e4); busy_cnt = 32'(b4);
    valid = 1'b0;
    repeat (FL * 4 + 6) begin
      step();
      strobes += 32'(e4); busy_cnt += 32'(b4);
    end
    check("div4_strobes", strobes, FL);
    check("div4_busy_cycles", busy_cnt, FL * 4);
    idle(10);

    // Back-to-back 8'hFF then 8'h00 with valid held.
    valid = 1'b1; data_in = 8'hFF; acc = '0;
    for (int c = 1; c <= 2 * FL; c++) begin
      step();
      check($sformatf("b2b_ready_c%0d", c), r1, (c == FL) || (c == 2 * FL));
      check($sformatf("b2b_busy_c%0d", c), b1, 1);
      acc = (acc << 1) | 32'(s1);
      if (c == 1) data_in = 8'h00;
      if (c == 2 * FL) valid = 1'b0;
    end
    want = 32'({frame_bits(8'hFF), frame_bits(8'h00)});
    check("b2b_bits", acc, want);
    step();
    check("b2b_end {ready,busy}", {r1, b1}, 2'b10);
    idle(40);

    // Reset on the third cycle of frame 8'hC3.
    valid = 1'b1; data_in = 8'hC3;
    step();
    valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    check("rst_so", s1, 0);
    step();
    check("rst_outputs", {r1, b1, s1, e1}, 4'b0000);
    reset = 1'b0;
    step();
    check("rst_release_ready", r1, 1);
    repeat (10) begin
      step();
      check("rst_no_residue {busy,so}", {b1, s1}, 2'b00);
    end
    idle(40);

    // valid with 8'h55 mid-frame must be ignored.
    valid = 1'b1; data_in = 8'h0F;
    step();
    acc = 32'(s1);
    for (int c = 2; c <= FL; c++) begin
      valid   = (c == 4);
      data_in = (c == 4) ? 8'h55 : 8'h0F;
      step();
      acc = (acc << 1) | 32'(s1);
    end
    valid = 1'b0;
    check("ignore_valid_bits", acc, 32'(frame_bits(8'h0F)));
    step();
    check("ignore_valid_idle {ready,busy}", {r1, b1}, 2'b10);
    idle(40);

`ifdef SERIALIZER_PARITY_EN
    valid = 1'b1; data_in = 8'h07;
    step();
    valid = 1'b0;
    repeat (FL - 1) step();
    check("parity_07", s1, 1);
    idle(40);
    valid = 1'b1; data_in = 8'h03;
    step();
    valid = 1'b0;
    repeat (FL - 1) step();
    check("parity_03", s1, 0);
    idle(40);
`endif

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 600; k++) begin
      reset   = ($urandom_range(0, 63) == 0);
      valid   = 1'($urandom_range(0, 1));
      data_in = 8'($urandom);
      step();
    end
    idle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data word width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter DIV, default 1, meaning clk cycles per serial bit (legal range 1..256).
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous reset, active-high.
REQ-005 data_in  input  WIDTH  parallel word to transmit.
REQ-006 valid  input  1  data_in is valid; a transfer occurs at a rising edge with valid=1 and ready=1.
REQ-007 ready  output  1  block accepts a word at this edge.
REQ-008 so  output  1  serial data out, MSB first; feeds the serial-in of the 110 sequence detector.
REQ-009 bit_en  output  1  one-cycle strobe on the first clk cycle of each serial bit.
REQ-010 busy  output  1  a frame is being shifted out.

Function
REQ-011 The FSM SHALL have two states: IDLE and SHIFT.
REQ-012 In IDLE, the outputs SHALL be ready=1, busy=0, so=0 and bit_en=0.
REQ-013 IDLE->SHIFT SHALL occur on transfer; the word is captured into the shift register at that edge.
REQ-014 The first bit (data_in[WIDTH-1]) SHALL appear on so the cycle after transfer, with bit_en=1 and busy=1.
REQ-015 Each bit SHALL be held on so for exactly DIV clk cycles, with bit_en high only on the first of those cycles.
REQ-016 When DIV=1, bit_en SHALL be 1 on every SHIFT cycle.
REQ-017 The frame SHALL comprise FRAME_LEN bits, where FRAME_LEN=WIDTH, or WIDTH+1 per REQ-026.
REQ-018 In SHIFT, ready SHALL be 0, except on the last clk cycle of the last bit, where ready=1.
REQ-019 A transfer on the cycle of REQ-018 SHALL start the next frame with zero gap: state stays SHIFT and the next MSB is on so on the following cycle.
REQ-020 If no transfer occurs on the cycle of REQ-018, the FSM SHALL return to IDLE and so SHALL drop to 0 the next cycle.
REQ-021 valid asserted while ready=0 SHALL be ignored, and data_in SHALL not be sampled.
REQ-022 The prescaler counter SHALL count 0..DIV-1 and wrap; the bit counter SHALL count 0..FRAME_LEN-1.
REQ-023 Both counters SHALL clear on every transfer.

Reset
REQ-024 While reset=1, the block SHALL drive ready=0, busy=0, so=0 and bit_en=0, and clear both counters and the shift register.
REQ-025 Reset mid-frame SHALL abort the frame with no further bits emitted; ready=1 (IDLE) SHALL follow on the first cycle after reset deasserts.

Configuration
REQ-026 With macro SERIALIZER_PARITY_EN defined, FRAME_LEN SHALL be WIDTH+1, the extra final bit being even parity (XOR of the captured word) held for DIV cycles with its own bit_en strobe.
REQ-027 Without SERIALIZER_PARITY_EN, FRAME_LEN SHALL be WIDTH, and no parity logic SHALL be synthesized.

Structure
REQ-028 A shared package bit_serializer_pkg SHALL hold the state encoding (IDLE, SHIFT), the counter-width helper (clog2), and FRAME_LEN derivation.
REQ-029 The prescaler SHALL be a sub-module bit_tick_gen (inputs clk, reset, clear; output tick, DIV-parametrized) instantiated once.

Verification
REQ-030 WIDTH=8, DIV=1, word 8'b1101_0110 -> so=1,1,0,1,0,1,1,0 on 8 consecutive cycles; the detector downstream pulses after both 110 occurrences.
REQ-031 DIV=4, word 8'hA5 -> each bit held 4 cycles, bit_en every 4th cycle (8 strobes), busy high for 32 cycles.
REQ-032 Back-to-back words 8'hFF then 8'h00 with valid held high -> 16 contiguous bits, no idle cycle, and ready high only on cycles 8 and 16.
REQ-033 Reset asserted on cycle 3 of frame 8'hC3 -> so=0 during reset, and ready=1 the cycle after reset release, with no residual bits.
REQ-034 SERIALIZER_PARITY_EN defined, word 8'h07 -> 9 bits, last bit=1; word 8'h03 -> last bit=0.
REQ-035 valid pulsed while busy with 8'h55 -> ignored, and the current frame completes unchanged.
